divisor_dispatcher: RTL and testbench
=====================================

# divisor_dispatcher

Upstream issue stage for the algorithmic divider. Buffers incoming numerator/denominator pairs in a small FIFO and launches one division at a time through the divider's Start/Num/Den/Coc/Res/Done interface. It handles divide-by-zero locally without starting the divider. Results are returned in order on a valid/ready output port.

## Interface

Parameters:
- tamanyo, 32, operand/result width in bits
- DEPTH, 4, input FIFO entries (power of two, ≥2)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RSTa  in  1  reset; one clock, reset is asynchronous and active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO can accept (= not full)
- in_num  in  tamanyo  numerator
- in_den  in  tamanyo  denominator
- div_start  out  1  one-cycle start pulse to divider
- div_num  out  tamanyo  numerator to divider, registered
- div_den  out  tamanyo  denominator to divider, registered
- div_coc  in  tamanyo  quotient from divider
- div_res  in  tamanyo  remainder from divider
- div_done  in  1  divider result valid
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_coc  out  tamanyo  quotient
- out_res  out  tamanyo  remainder
- out_dz  out  1  result came from a divide-by-zero
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation

- FIFO:
  - Push on in_valid && in_ready.
  - in_ready depends only on full; a push is refused when full even if a pop occurs in the same cycle.
  - No bypass: a pushed entry is visible at the head on the next cycle.
  - Pop and push in the same cycle are allowed when not full; count is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, FIFO empty: stay in IDLE.
- IDLE, head den ≠ 0: pop the head, load it into div_num/div_den, go to ISSUE.
- IDLE, head den = 0: pop the head and load the output registers directly:
  - out_coc = all ones, out_res = num, out_dz = 1.
  - Go to HOLD. The divider is not started.
- ISSUE: div_start = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - div_num/div_den are held stable.
  - On div_done = 1: capture div_coc→out_coc, div_res→out_res, set out_dz = 0, go to HOLD.
- HOLD:
  - out_valid = 1; out_coc/out_res/out_dz are held stable.
  - On out_ready = 1, the result is consumed and the FSM goes to IDLE.
- div_done is ignored in every state except WAIT.
- Results leave in the same order the pairs were accepted.
- Reset, including mid-operation:
  - FIFO emptied, count = 0, FSM to IDLE.
  - out_valid = 0, div_start = 0, all data outputs = 0.
  - in_ready = 1 during and after reset.
  - A division already in flight is abandoned; its later div_done is ignored.

## Timing

- Pair pushed at edge 0 → popped at edge 1 → div_start high in cycle 2 → WAIT from cycle 3.
- div_done first seen high in cycle k → out_valid high in cycle k+1.
- Divide-by-zero: pushed at edge 0 → out_valid high in cycle 2.
- Minimum spacing between div_start pulses is 4 cycles.
- out_valid deasserts the cycle after the out_ready handshake.
- The next pop can occur on that same edge +1 (IDLE lasts ≥1 cycle).
- All outputs except in_ready are registered. in_ready is combinational from count.

## Test plan

- 100/7 with out_ready = 1:
  - div_start high exactly 1 cycle with div_num = 100, div_den = 7.
  - Model divider answers 14/2 → out_coc = 14, out_res = 2, out_dz = 0, out_valid one cycle after div_done.
- 55/0:
  - div_start never asserts.
  - out_coc = 0xFFFFFFFF, out_res = 55, out_dz = 1, out_valid in cycle 2 after the push.
- Back-to-back pushes with out_ready = 0 and DEPTH = 4:
  - 5 pairs accepted (1 in HOLD, 4 in FIFO); in_ready = 0 and count = 4; the 6th pair stalls.
  - After releasing out_ready, all 5 results emerge in order and the 6th is accepted once count < 4.
- out_ready held 0 for 10 cycles in HOLD:
  - out_valid, out_coc, out_res stay stable.
  - No div_start occurs while entries are queued.
- RSTa asserted during WAIT with 2 entries queued:
  - All outputs are 0 immediately and count = 0.
  - A later div_done pulse produces no out_valid.
- div_done pulsed while in IDLE with an empty FIFO → no state change, no out_valid.

Source files
------------

// File: rtl/divisor_dispatcher.sv
// divisor_dispatcher: issue stage in front of the algorithmic divider.
// Operand pairs are queued in a small FIFO, launched one at a time through the
// divider's start/done interface, and results are returned in arrival order.
// A zero denominator is answered locally (quotient all ones, remainder = num)
// without starting the divider.
//
// Handshake semantics (both in_* and out_* ports): a transfer happens on a
// rising CLK edge where valid && ready are both high. The producer holds valid
// and its data stable until the transfer; ready may change freely. in_ready is
// a function of FIFO fullness only, so a pop in the same cycle never frees a
// slot for a push.
module divisor_dispatcher #(
    parameter int tamanyo = 32,
    parameter int DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RSTa,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [tamanyo-1:0]         in_num,
    input  logic [tamanyo-1:0]         in_den,
    output logic                       div_start,
    output logic [tamanyo-1:0]         div_num,
    output logic [tamanyo-1:0]         div_den,
    input  logic [tamanyo-1:0]         div_coc,
    input  logic [tamanyo-1:0]         div_res,
    input  logic                       div_done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [tamanyo-1:0]         out_coc,
    output logic [tamanyo-1:0]         out_res,
    output logic                       out_dz,
    output logic [$clog2(DEPTH):0]     count,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [tamanyo-1:0] num_mem [DEPTH];
    logic [tamanyo-1:0] den_mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push, pop;
    logic [tamanyo-1:0] head_num, head_den;
    logic               head_dz;

    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign head_num  = num_mem[rd_ptr];
    assign head_den  = den_mem[rd_ptr];
    assign head_dz   = (head_den == '0);
    assign dbg_state = state;

    // FIFO storage: data only, no reset needed since occupancy guards reads
    always_ff @(posedge CLK) begin
        if (push) begin
            num_mem[wr_ptr] <= in_num;
            den_mem[wr_ptr] <= in_den;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state and pop decision; the head is only taken from IDLE
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = head_dz ? HOLD : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT:  if (div_done) state_nxt = HOLD;
            HOLD:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered divider request and result outputs
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            div_start <= 1'b0;
            div_num   <= '0;
            div_den   <= '0;
            out_valid <= 1'b0;
            out_coc   <= '0;
            out_res   <= '0;
            out_dz    <= 1'b0;
        end else begin
            // start is high exactly while the FSM sits in ISSUE
            div_start <= pop && !head_dz;
            if (pop && !head_dz) begin
                div_num <= head_num;
                div_den <= head_den;
            end
            if (pop && head_dz) begin
                out_coc   <= '1;
                out_res   <= head_num;
                out_dz    <= 1'b1;
                out_valid <= 1'b1;
            end else if (state == WAIT && div_done) begin
                out_coc   <= div_coc;
                out_res   <= div_res;
                out_dz    <= 1'b0;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divisor_dispatcher.sv
// Directed bench for divisor_dispatcher with a small divider responder.
module tb_divisor_dispatcher;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = $clog2(D) + 1;

    logic          CLK = 1'b0;
    logic          RSTa = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_num = '0;
    logic [W-1:0]  in_den = '0;
    logic          div_start;
    logic [W-1:0]  div_num, div_den;
    logic [W-1:0]  div_coc, div_res;
    logic          div_done;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_coc, out_res;
    logic          out_dz;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;

    // divider responder (auto) and manual done driver
    logic          auto_en = 1'b0;
    logic          auto_done = 1'b0;
    logic [W-1:0]  auto_coc = '0, auto_res = '0;
    logic          man_done = 1'b0;
    logic [W-1:0]  man_coc = '0, man_res = '0;
    logic          busy = 1'b0;
    int            lat = 0;
    logic [W-1:0]  a_num = '0, a_den = '1;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [64:0] exp_q[$];

    assign div_done = auto_done | man_done;
    assign div_coc  = auto_done ? auto_coc : man_coc;
    assign div_res  = auto_done ? auto_res : man_res;

    divisor_dispatcher #(.tamanyo(W), .DEPTH(D)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_coc(out_coc), .out_res(out_res), .out_dz(out_dz),
        .count(count), .dbg_state(dbg_state)
    );

    // clock
    always #5 CLK = ~CLK;

    // count divider start pulses
    always @(posedge CLK) if (div_start === 1'b1) start_cnt++;

    // divider model: answers three cycles after seeing start
    always @(posedge CLK) begin
        auto_done <= 1'b0;
        if (RSTa || !auto_en) begin
            busy <= 1'b0;
        end else if (div_start && !busy) begin
            busy  <= 1'b1;
            lat   <= 2;
            a_num <= div_num;
            a_den <= div_den;
        end else if (busy) begin
            if (lat == 0) begin
                auto_done <= 1'b1;
                auto_coc  <= a_num / a_den;
                auto_res  <= a_num % a_den;
                busy      <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // hard time limit
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pair(input logic [W-1:0] n, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        tick();
        in_valid = 1'b0;
    endtask

    logic [W-1:0] bb_num [6] = '{32'd20, 32'd9, 32'd50, 32'd7, 32'd1000, 32'd81};
    logic [W-1:0] bb_den [6] = '{32'd3,  32'd0, 32'd5,  32'd9, 32'd33,   32'd4};

    // directed stimulus
    initial begin
        int s0;
        logic [64:0] e;
        logic acc5, took;

        // reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_out_coc", out_coc, 0);
        RSTa = 1'b0;
        tick();

        // 100 / 7 through the divider
        auto_en   = 1'b1;
        out_ready = 1'b1;
        s0 = start_cnt;
        push_pair(32'd100, 32'd7);
        chk("t1_count_after_push", count, 1);
        chk("t1_no_start_yet", div_start, 0);
        tick();
        chk("t1_start", div_start, 1);
        chk("t1_div_num", div_num, 100);
        chk("t1_div_den", div_den, 7);
        chk("t1_count_after_pop", count, 0);
        tick();
        chk("t1_start_low", div_start, 0);
        chk("t1_state_wait", dbg_state, 2'd2);
        for (int i = 0; i < 20 && !div_done; i++) tick();
        chk("t1_done_seen", div_done, 1);
        chk("t1_valid_not_yet", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_coc", out_coc, 14);
        chk("t1_res", out_res, 2);
        chk("t1_dz", out_dz, 0);
        tick();
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_one_start", start_cnt - s0, 1);

        // 55 / 0 handled locally
        s0 = start_cnt;
        push_pair(32'd55, 32'd0);
        chk("t2_valid_not_yet", out_valid, 0);
        tick();
        chk("t2_valid", out_valid, 1);
        chk("t2_coc", out_coc, 32'hFFFF_FFFF);
        chk("t2_res", out_res, 55);
        chk("t2_dz", out_dz, 1);
        tick();
        chk("t2_valid_drop", out_valid, 0);
        chk("t2_state_idle", dbg_state, 2'd0);
        chk("t2_no_start", start_cnt - s0, 0);

        // back-to-back with consumer stalled
        out_ready = 1'b0;
        exp_q = {};
        exp_q.push_back({1'b0, 32'd6,          32'd2});
        exp_q.push_back({1'b1, 32'hFFFF_FFFF,  32'd9});
        exp_q.push_back({1'b0, 32'd10,         32'd0});
        exp_q.push_back({1'b0, 32'd0,          32'd7});
        exp_q.push_back({1'b0, 32'd30,         32'd10});
        exp_q.push_back({1'b0, 32'd20,         32'd1});
        for (int i = 0; i < 5; i++) push_pair(bb_num[i], bb_den[i]);
        chk("t3_count_full", count, 4);
        chk("t3_in_ready_low", in_ready, 0);
        in_valid = 1'b1;
        in_num   = bb_num[5];
        in_den   = bb_den[5];
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        chk("t3_hold_valid", out_valid, 1);
        s0 = start_cnt;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_stable_valid", out_valid, 1);
            chk("t3_stable_coc", out_coc, 6);
            chk("t3_stable_res", out_res, 2);
        end
        chk("t3_still_full", count, 4);
        chk("t3_sixth_stalled", in_ready, 0);
        chk("t3_no_start_in_hold", start_cnt - s0, 0);

        out_ready = 1'b1;
        acc5 = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            took = 1'b0;
            if (out_valid) begin
                e = exp_q.pop_front();
                chk("t3_order_dz", out_dz, e[64]);
                chk("t3_order_coc", out_coc, e[63:32]);
                chk("t3_order_res", out_res, e[31:0]);
            end
            if (!acc5 && in_valid && in_ready) took = 1'b1;
            tick();
            if (took) begin
                acc5     = 1'b1;
                in_valid = 1'b0;
            end
        end
        chk("t3_all_results", exp_q.size(), 0);
        chk("t3_sixth_accepted", acc5, 1);
        in_valid = 1'b0;
        tick();

        // reset while WAIT with two entries queued
        auto_en = 1'b0;
        push_pair(32'd30, 32'd4);
        push_pair(32'd40, 32'd5);
        push_pair(32'd60, 32'd7);
        chk("t4_state_wait", dbg_state, 2'd2);
        chk("t4_count_two", count, 2);
        chk("t4_div_num", div_num, 30);
        RSTa = 1'b1;
        #1;
        chk("t4_rst_count", count, 0);
        chk("t4_rst_in_ready", in_ready, 1);
        chk("t4_rst_valid", out_valid, 0);
        chk("t4_rst_start", div_start, 0);
        chk("t4_rst_div_num", div_num, 0);
        chk("t4_rst_div_den", div_den, 0);
        chk("t4_rst_coc", out_coc, 0);
        chk("t4_rst_res", out_res, 0);
        chk("t4_rst_dz", out_dz, 0);
        chk("t4_rst_state", dbg_state, 2'd0);
        tick();
        chk("t4_rst_in_ready_hold", in_ready, 1);
        RSTa = 1'b0;
        s0 = start_cnt;
        man_coc  = 32'd7;
        man_res  = 32'd2;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t4_late_done_no_valid", out_valid, 0);
        chk("t4_count_after", count, 0);
        chk("t4_no_start", start_cnt - s0, 0);

        // stray done in IDLE with empty FIFO
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        chk("t5_state_idle", dbg_state, 2'd0);
        tick();
        chk("t5_no_valid", out_valid, 0);
        chk("t5_count", count, 0);

        // still operational afterwards
        auto_en = 1'b1;
        push_pair(32'd12, 32'd4);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk("t6_valid", out_valid, 1);
        chk("t6_coc", out_coc, 3);
        chk("t6_res", out_res, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
